// File: rtl/mc_sequencer.sv
// Multi-cycle processor control sequencer: Moore FSM driving datapath controls,
// with a bounded memory-acknowledge wait and a saturating retired-instruction counter.
module mc_sequencer #(
    parameter int OPCODE_WIDTH = 6,
    parameter int WAIT_LIMIT   = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    mem_ack,
    output logic                    pc_write,
    output logic                    pc_write_cond,
    output logic                    i_or_d,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    mem_to_reg,
    output logic                    ir_write,
    output logic                    alu_src_a,
    output logic                    reg_write,
    output logic                    reg_dst,
    output logic [1:0]              pc_source,
    output logic [1:0]              alu_op,
    output logic [1:0]              alu_src_b,
    output logic                    mem_req,
    output logic [3:0]              state,
    output logic                    halted,
    output logic                    error,
    output logic [CNT_WIDTH-1:0]    instr_count
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_R = 4'd2;
    localparam logic [3:0] S_EXEC_I = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_MEM_WR = 4'd6;
    localparam logic [3:0] S_WB_R   = 4'd7;
    localparam logic [3:0] S_WB_I   = 4'd8;
    localparam logic [3:0] S_WB_MEM = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_HALT   = 4'd12;
    localparam logic [3:0] S_ERROR  = 4'd13;

    localparam int WCNT_WIDTH = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCNT_WIDTH-1:0] WAIT_LAST = WCNT_WIDTH'(WAIT_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};

    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = {2'b10, {(OPCODE_WIDTH-2){1'b0}}};
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = OP_LOAD | OPCODE_WIDTH'(1'b1);
    localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = {2'b11, {(OPCODE_WIDTH-2){1'b0}}};
    localparam logic [OPCODE_WIDTH-1:0] OP_JUMP   = OP_BRANCH | OPCODE_WIDTH'(1'b1);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT   = {OPCODE_WIDTH{1'b1}};

    logic [3:0]              state_q, state_d;
    logic [WCNT_WIDTH-1:0]   wait_q, wait_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic                    waiting_s;
    logic                    retire_s;
    logic [3:0]              ack_next_s;

    // Next-state, wait-counter and retire-counter logic.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        waiting_s  = 1'b0;
        retire_s   = 1'b0;
        ack_next_s = state_q;
        wait_d     = {WCNT_WIDTH{1'b0}};
        count_d    = count_q;

        case (state_q)
            S_FETCH: begin
                waiting_s  = 1'b1;
                ack_next_s = S_DECODE;
            end
            S_DECODE: begin
                opcode_d = opcode;
                if (opcode[OPCODE_WIDTH-1 -: 2] == 2'b00) begin
                    state_d = S_EXEC_R;
                end else if (opcode[OPCODE_WIDTH-1 -: 2] == 2'b01) begin
                    state_d = S_EXEC_I;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = S_ADDR;
                end else if (opcode == OP_BRANCH) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_JUMP) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            // Load/store choice uses the opcode captured in DECODE, not the live input.
            S_ADDR: begin
                if (opcode_q == OP_STORE) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                waiting_s  = 1'b1;
                ack_next_s = S_WB_MEM;
            end
            S_MEM_WR: begin
                waiting_s  = 1'b1;
                ack_next_s = S_FETCH;
            end
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        // An acknowledge in the final permitted cycle still completes normally.
        if (waiting_s) begin
            if (mem_ack) begin
                state_d  = ack_next_s;
                retire_s = (state_q == S_MEM_WR);
            end else if (wait_q == WAIT_LAST) begin
                state_d = S_ERROR;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end else begin
            wait_d = {WCNT_WIDTH{1'b0}};
        end

        if (retire_s && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end else begin
            count_d = count_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_q   <= {WCNT_WIDTH{1'b0}};
            opcode_q <= {OPCODE_WIDTH{1'b0}};
            count_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
        end
    end

    // Moore control decode; FETCH adds the acknowledge-qualified PC/IR update.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        alu_src_b     = 2'b00;
        mem_req       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                if (mem_ack && !reset) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                end else begin
                    ir_write  = 1'b0;
                end
            end
            S_DECODE: alu_src_b = 2'b11;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_WB_I:   reg_write = 1'b1;
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: mem_req = 1'b0;
        endcase
    end

    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign error       = (state_q == S_ERROR);
    assign instr_count = count_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized self-checking bench for mc_sequencer using an instruction-level
// reference model that expands each instruction into its expected cycle plan.
module tb_mc_sequencer;
    localparam int WL      = 4;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode;
    logic          mem_ack;
    logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
    logic          ir_write, alu_src_a, reg_write, reg_dst, mem_req, halted, error;
    logic [1:0]    pc_source, alu_op, alu_src_b;
    logic [3:0]    state;
    logic [CW-1:0] instr_count;
    logic [16:0]   ctrl_s;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    typedef struct { int st; int ack; } cyc_t;

    mc_sequencer #(.OPCODE_WIDTH(6), .WAIT_LIMIT(WL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ack(mem_ack),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .alu_src_a(alu_src_a), .reg_write(reg_write),
        .reg_dst(reg_dst), .pc_source(pc_source), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .mem_req(mem_req), .state(state),
        .halted(halted), .error(error), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign ctrl_s = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
                     ir_write, alu_src_a, reg_write, reg_dst, pc_source, alu_op,
                     alu_src_b, mem_req};

    // Control word each state must show, taken from the state table.
    function automatic logic [16:0] exp_ctrl(input int st, input logic ack);
        logic pw, pwc, iod, mr, mw, mtr, irw, asa, rw, rd, mq;
        logic [1:0] ps, ao, asb;
        {pw, pwc, iod, mr, mw, mtr, irw, asa, rw, rd, mq} = 11'b0;
        ps = 2'b00; ao = 2'b00; asb = 2'b00;
        case (st)
            0:  begin mq = 1'b1; mr = 1'b1;
                      if (ack) begin irw = 1'b1; pw = 1'b1; asb = 2'b01; end end
            1:  asb = 2'b11;
            2:  begin asa = 1'b1; ao = 2'b10; end
            3:  begin asa = 1'b1; asb = 2'b10; ao = 2'b11; end
            4:  begin asa = 1'b1; asb = 2'b10; end
            5:  begin mq = 1'b1; mr = 1'b1; iod = 1'b1; end
            6:  begin mq = 1'b1; mw = 1'b1; iod = 1'b1; end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8:  rw = 1'b1;
            9:  begin rw = 1'b1; mtr = 1'b1; end
            10: begin asa = 1'b1; ao = 2'b01; pwc = 1'b1; ps = 2'b01; end
            11: begin pw = 1'b1; ps = 2'b10; end
            default: mq = 1'b0;
        endcase
        return {pw, pwc, iod, mr, mw, mtr, irw, asa, rw, rd, ps, ao, asb, mq};
    endfunction

    // cls: 0=R 1=I 2=load 3=store 4=branch 5=jump
    function automatic logic [5:0] class_opcode(input int cls);
        case (cls)
            0:       return {2'b00, 4'($urandom)};
            1:       return {2'b01, 4'($urandom)};
            2:       return 6'b100000;
            3:       return 6'b100001;
            4:       return 6'b110000;
            default: return 6'b110001;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        mem_ack = 1'b0;
        step();
        reset   = 1'b0;
        exp_cnt = 0;
    endtask

    // Expand one instruction into its cycle plan, drive it, and check every cycle.
    task automatic run_instr(input int cls, input logic [5:0] op, input int df,
                             input int dm, input string tag);
        cyc_t plan[$];
        int   ws;
        bit   to = 1'b0;
        int   end_st;
        for (int k = 0; k <= df; k++) plan.push_back('{0, (k == df) ? 1 : 0});
        plan.push_back('{1, 2});
        case (cls)
            0:       begin plan.push_back('{2, 2}); plan.push_back('{7, 2}); end
            1:       begin plan.push_back('{3, 2}); plan.push_back('{8, 2}); end
            4:       plan.push_back('{10, 2});
            5:       plan.push_back('{11, 2});
            default: begin
                ws = (cls == 2) ? 5 : 6;
                plan.push_back('{4, 2});
                if (dm < WL) begin
                    for (int k = 0; k <= dm; k++) plan.push_back('{ws, (k == dm) ? 1 : 0});
                end else begin
                    for (int k = 0; k < WL; k++) plan.push_back('{ws, 0});
                    to = 1'b1;
                end
                if (cls == 2 && !to) plan.push_back('{9, 2});
            end
        endcase
        if (!to && exp_cnt < CNT_MAX) exp_cnt++;
        end_st = to ? 13 : 0;

        for (int i = 0; i < plan.size(); i++) begin
            mem_ack = (plan[i].ack == 2) ? 1'($urandom) : 1'(plan[i].ack);
            opcode  = (i <= df + 1) ? op : 6'($urandom);
            #1;
            checks++;
            if (state !== 4'(plan[i].st)) begin
                failures++;
                $display("FAIL %s cyc%0d state: got %0d want %0d", tag, i, state, plan[i].st);
            end
            checks++;
            if (ctrl_s !== exp_ctrl(plan[i].st, mem_ack) || halted !== 1'b0 || error !== 1'b0) begin
                failures++;
                $display("FAIL %s cyc%0d ctrl: got %05h h%0b e%0b want %05h h0 e0", tag, i,
                         ctrl_s, halted, error, exp_ctrl(plan[i].st, mem_ack));
            end
            step();
        end
        mem_ack = 1'b0;
        #1;
        checks++;
        if (state !== 4'(end_st) || ctrl_s !== exp_ctrl(end_st, 1'b0) || error !== to) begin
            failures++;
            $display("FAIL %s end: got state %0d ctrl %05h err %0b want state %0d ctrl %05h err %0b",
                     tag, state, ctrl_s, error, end_st, exp_ctrl(end_st, 1'b0), to);
        end
        checks++;
        if (instr_count !== CW'(exp_cnt)) begin
            failures++;
            $display("FAIL %s count: got %0d want %0d", tag, instr_count, exp_cnt);
        end
        #(-1 + 1);
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ack = 1'b1; opcode = 6'b000000;
        step(); step();
        checks++;
        if (state !== 4'd0 || instr_count !== '0 || halted !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got st%0d cnt%0d h%0b e%0b want st0 cnt0 h0 e0",
                     state, instr_count, halted, error);
        end
        checks++;
        if (ir_write !== 1'b0 || pc_write !== 1'b0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got irw%0b pcw%0b mw%0b want 0 0 0", ir_write, pc_write, mem_write);
        end
        reset = 1'b0; mem_ack = 1'b0; exp_cnt = 0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_read !== 1'b1 || i_or_d !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got req%0b rd%0b iod%0b want 1 1 0", mem_req, mem_read, i_or_d);
        end
        step();
    endtask

    task automatic test_rtype();
        do_reset();
        run_instr(0, 6'b000010, 0, 0, "rtype");
    endtask

    task automatic test_load_wait();
        do_reset();
        run_instr(2, 6'b100000, 0, 3, "load_wait");
        run_instr(3, 6'b100001, 2, 1, "store_wait");
    endtask

    task automatic test_timeout();
        do_reset();
        mem_ack = 1'b0;
        for (int i = 0; i < WL; i++) begin
            checks++;
            if (state !== 4'd0) begin
                failures++;
                $display("FAIL timeout_wait%0d: got %0d want 0", i, state);
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 4'd13 || error !== 1'b1 || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL timeout_err%0d: got st%0d e%0b req%0b want st13 e1 req0",
                         i, state, error, mem_req);
            end
            mem_ack = 1'($urandom);
            opcode  = 6'($urandom);
            step();
        end
        do_reset();
        run_instr(3, 6'b100001, 0, WL, "store_timeout");
    endtask

    task automatic test_illegal_halt();
        do_reset();
        opcode = 6'b101010; mem_ack = 1'b1;
        step(); step();
        checks++;
        if (state !== 4'd13 || error !== 1'b1 || halted !== 1'b0) begin
            failures++;
            $display("FAIL illegal: got st%0d e%0b h%0b want st13 e1 h0", state, error, halted);
        end
        do_reset();
        run_instr(1, 6'b010011, 1, 0, "pre_halt");
        opcode = 6'b111111; mem_ack = 1'b1;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 4'd12 || halted !== 1'b1 || error !== 1'b0 || instr_count !== 2'd1) begin
                failures++;
                $display("FAIL halt%0d: got st%0d h%0b e%0b cnt%0d want st12 h1 e0 cnt1",
                         i, state, halted, error, instr_count);
            end
            mem_ack = 1'($urandom);
            opcode  = 6'($urandom);
            step();
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        run_instr(5, 6'b110001, 0, 0, "pre_store");
        opcode = 6'b100001; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step(); step();
        #1;
        checks++;
        if (state !== 4'd6 || mem_write !== 1'b1 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_write_pre: got st%0d mw%0b req%0b want st6 mw1 req1", state, mem_write, mem_req);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || instr_count !== '0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL mid_write_reset: got st%0d cnt%0d mw%0b want st0 cnt0 mw0",
                     state, instr_count, mem_write);
        end
        step();
        reset = 1'b0; exp_cnt = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) run_instr(5, 6'b110001, $urandom_range(0, 3), 0, "jump_sat");
        checks++;
        if (instr_count !== 2'd3) begin
            failures++;
            $display("FAIL saturation: got %0d want 3", instr_count);
        end
    endtask

    task automatic test_random();
        int cls;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 5);
            run_instr(cls, class_opcode(cls), $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0; opcode = 6'b000000;
        test_reset();
        test_rtype();
        test_load_wait();
        test_timeout();
        test_illegal_halt();
        test_reset_mid_write();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter OPCODE_WIDTH, default 6: width of the opcode field taken from the instruction register.
REQ-002 Parameter WAIT_LIMIT, default 16: maximum cycles a memory request may wait for an acknowledge.
REQ-003 Parameter CNT_WIDTH, default 32: width of the retired-instruction counter.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  OPCODE_WIDTH  instruction-register opcode field.
- mem_ack  in  1  memory has completed the current request this cycle.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst  out  1 each  datapath controls.
- pc_source, alu_op, alu_src_b  out  2 each  datapath mux and ALU selects.
- mem_req  out  1  memory request active.
- state  out  4  current state encoding.
- halted  out  1  HALT state reached.
- error  out  1  ERROR state reached.
- instr_count  out  CNT_WIDTH  retired instructions.

Function
REQ-006 States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_MEM=9, BRANCH=10, JUMP=11, HALT=12, ERROR=13. Encodings 14 and 15 SHALL go to ERROR.
REQ-007 Any control output not listed for a state SHALL be 0. All outputs SHALL be Moore outputs, except the mem_ack-qualified ones in REQ-008.
REQ-008 FETCH: mem_req=1, mem_read=1, i_or_d=0; hold until mem_ack=1. In the mem_ack cycle: ir_write=1, pc_write=1, pc_source=00, alu_src_a=0, alu_src_b=01, alu_op=00; next state DECODE.
REQ-009 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Dispatch on opcode:
- top two bits 00 -> EXEC_R
- top two bits 01 -> EXEC_I
- 100000 -> ADDR
- 100001 -> ADDR
- 110000 -> BRANCH
- 110001 -> JUMP
- all ones -> HALT
- any other value -> ERROR
REQ-010 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next WB_R. WB_R: reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-011 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11; next WB_I. WB_I: reg_write=1, reg_dst=0.
REQ-012 ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_RD for a load, MEM_WR for a store. The opcode SHALL be registered at DECODE and used here.
REQ-013 MEM_RD: mem_req=1, mem_read=1, i_or_d=1; hold until mem_ack; next WB_MEM. WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-014 MEM_WR: mem_req=1, mem_write=1, i_or_d=1; hold until mem_ack; next FETCH.
REQ-015 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next FETCH.
REQ-016 JUMP: pc_write=1, pc_source=10; next FETCH.
REQ-017 WB_R, WB_I and WB_MEM SHALL each be followed by FETCH.
REQ-018 HALT SHALL assert halted=1 and remain in HALT until reset. ERROR SHALL assert error=1 and remain in ERROR until reset.
REQ-019 Wait counter:
- Clears on entry to FETCH, MEM_RD or MEM_WR.
- Increments each cycle the block waits there with mem_ack=0.
- If it reaches WAIT_LIMIT with mem_ack still 0, next state is ERROR and mem_req drops.
- mem_ack=1 in the limit cycle wins: normal transition.
REQ-020 instr_count SHALL increment by 1 on every transition from MEM_WR, WB_R, WB_I, WB_MEM, BRANCH or JUMP to FETCH. It SHALL saturate at all ones.
REQ-021 mem_ack SHALL be ignored in states where mem_req=0.

Reset
REQ-022 When reset is asserted, state SHALL become FETCH, and the wait counter and instr_count SHALL become 0, with halted=0 and error=0, asynchronously, regardless of the current state. This includes reset asserted mid-wait.
REQ-023 During reset, all control outputs SHALL be 0 except the FETCH Moore outputs, which SHALL be present after reset release.

Verification
REQ-024 R-type: reset, opcode=000010, mem_ack=1 in each FETCH -> states 0,1,2,7,0; reg_write=1 with reg_dst=1 in WB_R; instr_count=1.
REQ-025 Load with a 3-cycle wait: opcode=100000, mem_ack held low 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles, then WB_MEM with mem_to_reg=1; instr_count increments.
REQ-026 Timeout: WAIT_LIMIT=4, mem_ack=0 permanently in FETCH -> ERROR after 4 cycles; error=1; mem_req=0; the block stays in ERROR.
REQ-027 Illegal and halt opcodes: opcode=101010 -> ERROR. Separately, opcode=111111 -> HALT with halted=1, and instr_count is unchanged.
REQ-028 Reset mid-MEM_WR (mem_req=1) -> state=0 immediately, without waiting for a clock edge; instr_count=0; mem_write=0.
REQ-029 Counter saturation: CNT_WIDTH=2, run 5 JUMP instructions -> instr_count=3.
